mc_ctrl_fsm: RTL and testbench

// - Multi-cycle control sequencer for the LoongArch single-issue core: drives pc/IR/regfile/data-SRAM write enables through IF/ID/EXE/MEM/WB.
// - Sits between the instruction decoder (class flags) and the shared ALU/regfile/SRAM datapath; one instruction in flight.
// - Stretches IF and MEM for SRAM latency and emits a commit pulse per retired instruction.

---
 rtl/mc_ctrl_fsm.sv | 110 +++++++++++
 tb/tb_mc_ctrl_fsm.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle IF/ID/EXE/MEM/WB sequencer with SRAM wait stretching and commit pulse.
// Optional perf counters enabled by defining MC_CTRL_PERF_CNT_EN.
module mc_ctrl_fsm #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        dec_br,
    input  logic        dec_load,
    input  logic        dec_store,
    input  logic        dec_gr_we,
    input  logic        dec_invalid,
    output logic [2:0]  state,
    output logic        ir_we,
    output logic        pc_we,
    output logic        rf_we,
    output logic        dsram_we,
    output logic        dsram_en,
    output logic        commit,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
);
    localparam int W = $clog2(MEM_LAT + 1);
    localparam logic [W-1:0] LAST = W'(MEM_LAT - 1);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    state_t st, nx;
    logic [W-1:0] wait_cnt;
    logic last, is_store;
    logic ir_c, pc_c, rf_c, dw_c, den_c, cm_c;

    assign last     = wait_cnt == LAST;
    assign is_store = dec_store & ~dec_load;

    always_comb begin
        nx    = S_IF;
        ir_c  = 1'b0;
        pc_c  = 1'b0;
        rf_c  = 1'b0;
        dw_c  = 1'b0;
        den_c = 1'b0;
        cm_c  = 1'b0;
        case (st)
            S_IF: begin
                ir_c = last;
                nx   = last ? S_ID : S_IF;
            end
            S_ID: begin
                pc_c = dec_invalid | dec_br;
                cm_c = ~dec_invalid & dec_br;
                nx   = (dec_invalid | dec_br) ? S_IF : S_EXE;
            end
            S_EXE: nx = (dec_load | dec_store) ? S_MEM : S_WB;
            S_MEM: begin
                den_c = 1'b1;
                dw_c  = is_store & (wait_cnt == '0);
                pc_c  = last & is_store;
                cm_c  = last & is_store;
                nx    = !last ? S_MEM : is_store ? S_IF : S_WB;
            end
            S_WB: begin
                rf_c = dec_gr_we;
                pc_c = 1'b1;
                cm_c = 1'b1;
            end
            default: nx = S_IF;
        endcase
    end

    // Strobes are gated by resetn so they fall immediately on reset assertion.
    assign state    = st;
    assign ir_we    = resetn & ir_c;
    assign pc_we    = resetn & pc_c;
    assign rf_we    = resetn & rf_c;
    assign dsram_we = resetn & dw_c;
    assign dsram_en = resetn & den_c;
    assign commit   = resetn & cm_c;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st       <= S_IF;
            wait_cnt <= '0;
        end else begin
            st       <= nx;
            wait_cnt <= (nx != st) ? '0 : wait_cnt + 1'b1;
        end
    end

`ifdef MC_CTRL_PERF_CNT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cycle_cnt   <= 32'h0;
            instret_cnt <= 32'h0;
        end else begin
            cycle_cnt   <= cycle_cnt + 32'd1;
            instret_cnt <= instret_cnt + {31'd0, commit};
        end
    end
`else
    assign cycle_cnt   = 32'h0;
    assign instret_cnt = 32'h0;
`endif
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: scoreboard bench for mc_ctrl_fsm at MEM_LAT=1 and MEM_LAT=3.
module tb_mc_ctrl_fsm;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1_n, rst3_n, br, ld, sb, gw, inv, sel;
    logic [2:0] s1, s3;
    logic ir1, pc1, rf1, dw1, de1, cm1, ir3, pc3, rf3, dw3, de3, cm3;
    logic [31:0] cc1, ic1, cc3, ic3;
    logic [8:0] obs, obs1, obs3;

    mc_ctrl_fsm #(.MEM_LAT(1)) dut1 (
        .clk(clk), .resetn(rst1_n), .dec_br(br), .dec_load(ld), .dec_store(sb),
        .dec_gr_we(gw), .dec_invalid(inv), .state(s1), .ir_we(ir1), .pc_we(pc1),
        .rf_we(rf1), .dsram_we(dw1), .dsram_en(de1), .commit(cm1),
        .cycle_cnt(cc1), .instret_cnt(ic1)
    );

    mc_ctrl_fsm #(.MEM_LAT(3)) dut3 (
        .clk(clk), .resetn(rst3_n), .dec_br(br), .dec_load(ld), .dec_store(sb),
        .dec_gr_we(gw), .dec_invalid(inv), .state(s3), .ir_we(ir3), .pc_we(pc3),
        .rf_we(rf3), .dsram_we(dw3), .dsram_en(de3), .commit(cm3),
        .cycle_cnt(cc3), .instret_cnt(ic3)
    );

    // Observed vector: {state, ir_we, pc_we, rf_we, dsram_we, dsram_en, commit}
    assign obs1 = {s1, ir1, pc1, rf1, dw1, de1, cm1};
    assign obs3 = {s3, ir3, pc3, rf3, dw3, de3, cm3};
    assign obs  = sel ? obs3 : obs1;

    typedef struct packed {
        logic [4:0] dec;
        logic [8:0] exp;
    } ent_t;

    localparam int K_ALU = 0, K_BR = 1, K_LD = 2, K_ST = 3, K_INV = 4, K_LDST = 5, K_NOP = 6;

    ent_t q[$];
    ent_t e;
    int checks = 0;
    int errors = 0;

    task automatic push_inst(input int lat, input int k);
        logic [4:0] d;
        logic fb, fl, fs, fg, fi;
        fb = (k == K_BR);
        fl = (k == K_LD) || (k == K_LDST);
        fs = (k == K_ST) || (k == K_LDST);
        fg = (k == K_ALU) || (k == K_LD) || (k == K_LDST);
        fi = (k == K_INV);
        d  = {fb, fl, fs, fg, fi};
        for (int i = 0; i < lat; i++)
            q.push_back('{d, {3'd0, (i == lat - 1), 5'b0}});
        if (fi) q.push_back('{d, {3'd1, 6'b010000}});
        else if (fb) q.push_back('{d, {3'd1, 6'b010001}});
        else begin
            q.push_back('{d, {3'd1, 6'b0}});
            q.push_back('{d, {3'd2, 6'b0}});
            if (fl || fs)
                for (int i = 0; i < lat; i++) begin
                    logic done;
                    done = (k == K_ST) && (i == lat - 1);
                    q.push_back('{d, {3'd3, 1'b0, done, 1'b0, (k == K_ST) && (i == 0), 1'b1, done}});
                end
            if (k != K_ST) q.push_back('{d, {3'd4, 1'b0, 1'b1, fg, 2'b00, 1'b1}});
        end
    endtask

    task automatic do_reset(input logic which);
        rst1_n = 1'b0;
        rst3_n = 1'b0;
        sel = which;
        #1;
        @(negedge clk);
        if (which) rst3_n = 1'b1;
        else rst1_n = 1'b1;
    endtask

    task automatic test_reset();
        rst1_n = 1'b0;
        rst3_n = 1'b0;
        {br, ld, sb, gw, inv} = 5'b11111;
        @(negedge clk);
        #1;
        checks++;
        if (obs1 !== 9'd0) begin errors++; $display("FAIL reset_l1: got %b expected %b", obs1, 9'd0); end
        checks++;
        if (obs3 !== 9'd0) begin errors++; $display("FAIL reset_l3: got %b expected %b", obs3, 9'd0); end
        @(negedge clk);
    endtask

    task automatic test_alu();
        int n = 0;
        do_reset(1'b0);
        repeat (3) push_inst(1, K_ALU);
        while (q.size() > 0) begin
            e = q.pop_front();
            {br, ld, sb, gw, inv} = e.dec;
            #1;
            checks++;
            if (obs !== e.exp) begin errors++; $display("FAIL alu cyc%0d: got %b expected %b", n, obs, e.exp); end
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_branch();
        int n = 0;
        do_reset(1'b0);
        repeat (3) push_inst(1, K_BR);
        while (q.size() > 0) begin
            e = q.pop_front();
            {br, ld, sb, gw, inv} = e.dec;
            #1;
            checks++;
            if (obs !== e.exp) begin errors++; $display("FAIL branch cyc%0d: got %b expected %b", n, obs, e.exp); end
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_load_store();
        int n = 0;
        do_reset(1'b1);
        push_inst(3, K_LD);
        push_inst(3, K_ST);
        push_inst(3, K_ALU);
        while (q.size() > 0) begin
            e = q.pop_front();
            {br, ld, sb, gw, inv} = e.dec;
            #1;
            checks++;
            if (obs !== e.exp) begin errors++; $display("FAIL ldst cyc%0d: got %b expected %b", n, obs, e.exp); end
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        do_reset(1'b1);
        push_inst(3, K_LDST);
        push_inst(3, K_INV);
        push_inst(3, K_NOP);
        push_inst(3, K_BR);
        push_inst(3, K_ST);
        while (q.size() > 0) begin
            e = q.pop_front();
            {br, ld, sb, gw, inv} = e.dec;
            #1;
            checks++;
            if (obs !== e.exp) begin errors++; $display("FAIL b2b cyc%0d: got %b expected %b", n, obs, e.exp); end
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_store();
        int n = 0;
        do_reset(1'b1);
        push_inst(3, K_ST);
        for (int i = 0; i < 6; i++) begin
            e = q.pop_front();
            {br, ld, sb, gw, inv} = e.dec;
            #1;
            checks++;
            if (obs !== e.exp) begin errors++; $display("FAIL midst cyc%0d: got %b expected %b", i, obs, e.exp); end
            if (i < 5) @(negedge clk);
        end
        #2;
        rst3_n = 1'b0;
        #1;
        checks++;
        if (obs3 !== 9'd0) begin errors++; $display("FAIL midst_async: got %b expected %b", obs3, 9'd0); end
        q.delete();
        @(negedge clk);
        rst3_n = 1'b1;
        push_inst(3, K_ALU);
        while (q.size() > 0) begin
            e = q.pop_front();
            {br, ld, sb, gw, inv} = e.dec;
            #1;
            checks++;
            if (obs !== e.exp) begin errors++; $display("FAIL midst_restart cyc%0d: got %b expected %b", n, obs, e.exp); end
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_perf();
        do_reset(1'b0);
        repeat (3) push_inst(1, K_ALU);
        push_inst(1, K_INV);
        while (q.size() > 0) begin
            e = q.pop_front();
            {br, ld, sb, gw, inv} = e.dec;
            @(negedge clk);
        end
`ifdef MC_CTRL_PERF_CNT_EN
        checks++;
        if (cc1 !== 32'd14) begin errors++; $display("FAIL perf_cycle: got %0d expected %0d", cc1, 14); end
        checks++;
        if (ic1 !== 32'd3) begin errors++; $display("FAIL perf_instret: got %0d expected %0d", ic1, 3); end
        force dut1.cycle_cnt = 32'hFFFF_FFFF;
        #1;
        release dut1.cycle_cnt;
        @(posedge clk);
        #1;
        checks++;
        if (cc1 !== 32'd0) begin errors++; $display("FAIL perf_wrap: got %h expected %h", cc1, 32'd0); end
`else
        checks++;
        if (cc1 !== 32'd0) begin errors++; $display("FAIL perf_cycle_tied: got %h expected %h", cc1, 32'd0); end
        checks++;
        if (ic1 !== 32'd0) begin errors++; $display("FAIL perf_instret_tied: got %h expected %h", ic1, 32'd0); end
`endif
    endtask

    initial begin
        sel = 1'b0;
        test_reset();
        test_alu();
        test_branch();
        test_load_store();
        test_back_to_back();
        test_reset_mid_store();
        test_perf();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
